// File: rtl/halfadder_checker.sv
// Hardware response checker for a half adder: counts samples and mismatches over a fixed-length run.
// Optional input-combination coverage is enabled by defining HALFADDER_CHECK_COV_EN.
module halfadder_checker #(
  parameter int unsigned NUM_SAMPLES = 50,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             cout,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_pulse,
  output logic [3:0]       first_err_vec,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [3:0]       cov_mask
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_SAMPLES - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_pulse;
  logic [3:0]       r_first_err_vec;
  logic [CNT_W-1:0] r_first_err_idx;
  logic             r_err_seen;
  logic             w_start_run;
  logic             w_accept;
  logic             w_last;
  logic             w_mismatch;
  logic             w_pass_cond;

  // start is ignored mid-run; from IDLE or DONE it wins over a coincident sample
  assign w_start_run = start && (r_state != StRun);
  assign w_accept    = in_valid && (r_state == StRun);
  assign w_last      = w_accept && (r_sample_cnt == LastCnt);
  assign w_mismatch  = (cout != (a & b)) || (s != (a ^ b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start)  w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  if (start)  w_state_next = StRun;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy = (r_state == StRun);
    done = (r_state == StDone);
    pass = done && w_pass_cond;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_cnt    <= '0;
      r_err_cnt       <= '0;
      r_err_pulse     <= 1'b0;
      r_first_err_vec <= 4'h0;
      r_first_err_idx <= '0;
      r_err_seen      <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_start_run) begin
        r_sample_cnt    <= '0;
        r_err_cnt       <= '0;
        r_first_err_vec <= 4'h0;
        r_first_err_idx <= '0;
        r_err_seen      <= 1'b0;
      end else if (w_accept) begin
        r_sample_cnt <= r_sample_cnt + 1'b1;
        if (w_mismatch) begin
          r_err_pulse <= 1'b1;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
          if (!r_err_seen) begin
            r_err_seen      <= 1'b1;
            r_first_err_vec <= {a, b, cout, s};
            r_first_err_idx <= r_sample_cnt;
          end
        end
      end
    end
  end

`ifdef HALFADDER_CHECK_COV_EN
  logic [3:0] r_cov_mask;
  logic [1:0] w_ab;

  assign w_ab = {a, b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cov_mask <= 4'h0;
    end else if (w_start_run) begin
      r_cov_mask <= 4'h0;
    end else if (w_accept) begin
      r_cov_mask[w_ab] <= 1'b1;
    end
  end

  assign cov_mask    = r_cov_mask;
  assign w_pass_cond = (r_err_cnt == '0) && (r_cov_mask == 4'hF);
`else
  assign cov_mask    = 4'h0;
  assign w_pass_cond = (r_err_cnt == '0);
`endif

  assign sample_cnt    = r_sample_cnt;
  assign err_cnt       = r_err_cnt;
  assign err_pulse     = r_err_pulse;
  assign first_err_vec = r_first_err_vec;
  assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_halfadder_checker.sv
// Scoreboard bench for halfadder_checker: driver pushes expected per-sample responses,
// a monitor pops and compares them after each clock edge; run-level results checked at run end.
module tb_halfadder_checker;

  localparam int unsigned N = 50;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         a = 1'b0, b = 1'b0, cout = 1'b0, s = 1'b0;
  logic         busy, done, pass, err_pulse;
  logic [W-1:0] sample_cnt, err_cnt, first_err_idx;
  logic [3:0]   first_err_vec, cov_mask;

  halfadder_checker #(.NUM_SAMPLES(N), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .cout(cout), .s(s),
    .busy(busy), .done(done), .pass(pass), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .err_pulse(err_pulse), .first_err_vec(first_err_vec), .first_err_idx(first_err_idx),
    .cov_mask(cov_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned pulse;
    int unsigned cnt;
    int unsigned errs;
    int unsigned busy;
    int unsigned done;
  } item_t;

  item_t q[$];
  int    n_cmp = 0;
  int    n_miss = 0;

  // Reference model: run phase (0 idle, 1 running, 2 finished) and run results
  int          m_st = 0;
  int unsigned m_cnt = 0, m_errs = 0, m_fidx = 0, m_fvec = 0, m_cov = 0;
  bit          m_seen = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_errs = 0; m_fidx = 0; m_fvec = 0; m_cov = 0; m_seen = 0;
  endtask

  task automatic drive(input bit st, input bit v, input bit ia, input bit ib,
                       input bit ic, input bit is);
    item_t it;
    bit    bad;
    @(negedge clk);
    start = st; in_valid = v; a = ia; b = ib; cout = ic; s = is;
    if (st && m_st != 1) begin
      m_st = 1;
      model_clear();
    end else if (v && m_st == 1) begin
      bad = (int'(ic) + 2 * int'(is)) != ((int'(ia) + int'(ib)) / 2 + 2 * ((int'(ia) + int'(ib)) % 2));
      m_cnt++;
      m_cov = m_cov | (1 << (2 * int'(ia) + int'(ib)));
      if (bad) begin
        if (m_errs < (1 << W) - 1) m_errs++;
        if (!m_seen) begin
          m_seen = 1;
          m_fidx = m_cnt - 1;
          m_fvec = 8 * int'(ia) + 4 * int'(ib) + 2 * int'(ic) + int'(is);
        end
      end
      if (m_cnt == N) m_st = 2;
      it.pulse = bad; it.cnt = m_cnt; it.errs = m_errs;
      it.busy = (m_st == 1); it.done = (m_st == 2);
      q.push_back(it);
    end
  endtask

  // Correct half-adder response for inputs ia/ib
  task automatic good(input bit st, input bit v, input bit ia, input bit ib);
    drive(st, v, ia, ib, ia & ib, ia ^ ib);
  endtask

  task automatic check_end(input string tag);
    int unsigned exp_pass, exp_cov;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
`ifdef HALFADDER_CHECK_COV_EN
    exp_cov  = m_cov;
    exp_pass = (m_st == 2) && (m_errs == 0) && (m_cov == 15);
`else
    exp_cov  = 0;
    exp_pass = (m_st == 2) && (m_errs == 0);
`endif
    chk({tag, ".done"}, done, m_st == 2);
    chk({tag, ".busy"}, busy, m_st == 1);
    chk({tag, ".pass"}, pass, exp_pass);
    chk({tag, ".sample_cnt"}, sample_cnt, m_cnt);
    chk({tag, ".err_cnt"}, err_cnt, m_errs);
    chk({tag, ".first_err_vec"}, first_err_vec, m_fvec);
    chk({tag, ".first_err_idx"}, first_err_idx, m_fidx);
    chk({tag, ".cov_mask"}, cov_mask, exp_cov);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".err_pulse"}, err_pulse, 0);
    chk({tag, ".sample_cnt"}, sample_cnt, 0);
    chk({tag, ".err_cnt"}, err_cnt, 0);
    chk({tag, ".first_err_vec"}, first_err_vec, 0);
    chk({tag, ".first_err_idx"}, first_err_idx, 0);
    chk({tag, ".cov_mask"}, cov_mask, 0);
  endtask

  // Monitor: one expected item per accepted sample, checked just after the accepting edge
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        #1;
        it = q.pop_front();
        chk("mon.err_pulse", err_pulse, it.pulse);
        chk("mon.sample_cnt", sample_cnt, it.cnt);
        chk("mon.err_cnt", err_cnt, it.errs);
        chk("mon.busy", busy, it.busy);
        chk("mon.done", done, it.done);
      end
    end
  end

  initial begin
    int unsigned cyc;
    bit ra, rb;
    bit [1:0] flip;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // No start: valid samples must be ignored
    for (int i = 0; i < 10; i++) good(0, 1, i[0], i[1]);
    check_end("idle");

    // Clean run cycling through all four combinations
    good(1, 0, 0, 0);
    for (int i = 0; i < N; i++) good(0, 1, i[1], i[0]);
    check_end("clean");

    // Single error at sample index 7 (a=1,b=1,cout=0,s=0)
    good(1, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      if (i == 7) drive(0, 1, 1, 1, 0, 0);
      else good(0, 1, i[1], i[0]);
    end
    check_end("err7");
    chk("err7.first_err_vec_lit", first_err_vec, 4'b1100);

    // Only a=0,b=0: coverage fails the run when enabled
    good(1, 0, 0, 0);
    for (int i = 0; i < N; i++) good(0, 1, 0, 0);
    check_end("cov00");

    // Reset mid-run after 20 samples, with a pending error to expose residue
    good(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) drive(0, 1, 0, 1, 1, 1);
      else good(0, 1, i[0], i[1]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    m_st = 0;
    model_clear();
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    good(1, 0, 0, 0);
    for (int i = 0; i < N; i++) good(0, 1, i[0], i[1]);
    check_end("after_rst");

    // From DONE: start with a coincident sample; that sample must not count
    good(1, 1, 1, 0);
    for (int i = 0; i < N; i++) good(0, 1, i[1], i[0]);
    check_end("start_coinc");

    // Randomized runs: gaps in in_valid, injected faults, stray start during the run
    for (int r = 0; r < 4; r++) begin
      good(1, 0, 0, 0);
      cyc = 0;
      while (m_st == 1 && cyc < 1000) begin
        ra = 1'($urandom); rb = 1'($urandom);
        flip = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), ra, rb,
              (ra & rb) ^ flip[1], (ra ^ rb) ^ flip[0]);
        cyc++;
      end
      chk("rand.bound", cyc < 1000, 1);
      check_end("rand");
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/halfadder_checker.md
# halfadder_checker

Synthesizable response checker for the half adder. It consumes sampled `{a, b, cout, s}` vectors, compares `cout`/`s` against the expected `a & b` / `a ^ b`, and counts samples and mismatches over a fixed-length run. It reports pass/fail and the first failing vector. It sits on the DUT output side, opposite the stimulus source, so half-adder checking runs in hardware instead of by `$monitor` inspection.

## Interface
- `NUM_SAMPLES`, 50: samples per run; legal range 1 .. 2^CNT_W-1.
- `CNT_W`, 8: width of the sample/error counters and the index.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a run.
- `in_valid` in 1: sample strobe; `a`/`b`/`cout`/`s` are valid this cycle.
- `a`, `b` in 1 each: stimulus applied to the DUT.
- `cout`, `s` in 1 each: DUT outputs under check.
- `busy` out 1: a run is in progress.
- `done` out 1: the run is complete; held until the next `start` or `rst`.
- `pass` out 1: valid while `done`=1; 1 means zero mismatches (and the coverage condition if enabled).
- `sample_cnt` out CNT_W: samples accepted in this run.
- `err_cnt` out CNT_W: mismatching samples; saturates at all-ones.
- `err_pulse` out 1: one-cycle pulse per mismatching sample.
- `first_err_vec` out 4: `{a,b,cout,s}` of the first mismatch in the run.
- `first_err_idx` out CNT_W: `sample_cnt` value at the first mismatch (0-based).
- `cov_mask` out 4: input-combination coverage (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state is IDLE. Every output is 0: `busy`, `done`, `pass`, `err_pulse`, both counters, `first_err_vec`, `first_err_idx`, `cov_mask`.
- IDLE --`start`--> RUN. The transition clears the counters, `first_err_*`, `cov_mask` and the "error seen" flag. `in_valid` is ignored in IDLE.
- In RUN, each `in_valid` cycle:
  - accept the sample and increment `sample_cnt`;
  - mismatch when `cout != (a & b)` or `s != (a ^ b)`;
  - on a mismatch, increment `err_cnt` (saturating) and pulse `err_pulse`;
  - on the first mismatch only, latch `first_err_vec` and `first_err_idx`.
- RUN --(accepted sample is number NUM_SAMPLES)--> DONE.
- DONE: assert `done` and drive `pass`. All outputs hold. Further `in_valid` is ignored.
- DONE --`start`--> RUN, with the same clearing as from IDLE.
- `start` while in RUN is ignored; the run is not restarted.
- X/Z on inputs are not checked; bench responsibility.

## Timing
- All outputs are registered.
- `sample_cnt` and `err_cnt` update on the clock edge that samples `in_valid`=1.
- `err_pulse` is high for exactly the cycle after that edge.
- `busy` goes high on the edge after `start`; `done` and `pass` go high on the edge that accepts the last sample. `busy` falls on that same edge.
- `start` and `in_valid` in the same cycle while in IDLE or DONE: `start` wins and the sample is not counted. The first countable sample arrives the following cycle.
- Back-to-back `in_valid` (every cycle) is supported; there is no backpressure.
- `rst` asserted mid-run: all state clears immediately (asynchronous) and the block returns to IDLE. No partial result is kept.
- Counter saturation: `err_cnt` stops at 2^CNT_W-1. `sample_cnt` never exceeds NUM_SAMPLES.

## Configuration
- `HALFADDER_CHECK_COV_EN` defined:
  - `cov_mask[{a,b}]` is set on every accepted sample;
  - `pass` = (`err_cnt`==0) && (`cov_mask`==4'hF), so a run that never applies all four input combinations fails.
- Not defined:
  - `cov_mask` is tied to 4'h0;
  - `pass` = (`err_cnt`==0).

## Test plan
- Reset then no `start`: drive `in_valid`=1 for 10 cycles → `sample_cnt`=0, `busy`=0, `done`=0.
- `start`, then 50 correct vectors cycling through {00,01,10,11} → `done`=1 one edge after the 50th sample, `pass`=1, `err_cnt`=0, `sample_cnt`=50; with the macro, `cov_mask`=4'hF.
- Sample 7 driven as a=1, b=1, cout=0, s=0, all others correct → `err_pulse` high once, `err_cnt`=1, `first_err_vec`=4'b1100, `first_err_idx`=7, `pass`=0.
- Macro defined, 50 correct vectors all with a=0, b=0 → `err_cnt`=0, `cov_mask`=4'h1, `pass`=0. Without the macro the same run gives `pass`=1.
- `rst` pulsed after 20 samples, then a fresh `start` plus 50 correct samples → no residue from the first run; `sample_cnt`=50, `pass`=1.
- `start` coincident with `in_valid` from DONE, then 50 samples → first sample not counted; `done` rises after the 50th following sample.
